// File: rtl/fp_max_reducer.sv
// ============================================================================
// Module   : fp_max_reducer
// Brief    : Streams a burst of floating-point words and returns the element of
//            largest (or smallest) magnitude together with its burst index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Unsigned magnitude comparator used on the exponent/mantissa field only.
module positive_comparator #(
    parameter int WIDTH = 31
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_a_gt_b,
    output logic             o_a_eq_b,
    output logic             o_b_gt_a
);
    assign o_a_gt_b = (i_a >  i_b);
    assign o_a_eq_b = (i_a == i_b);
    assign o_b_gt_a = (i_a <  i_b);
endmodule

module fp_max_reducer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  find_min,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LEN_WIDTH-1:0]  out_index,
    output logic                  out_empty,
    output logic                  busy
);

    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_best;
    logic [LEN_WIDTH-1:0]  r_best_idx;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_min;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_out_empty;
    logic                  r_busy;

    logic                  w_a_gt_b;
    logic                  w_a_eq_b;
    logic                  w_b_gt_a;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_last;

    // Sign bit is excluded: selection is purely on magnitude.
    positive_comparator #(
        .WIDTH (DATA_WIDTH-1)
    ) u_cmp (
        .i_a      (in_data[DATA_WIDTH-2:0]),
        .i_b      (r_best[DATA_WIDTH-2:0]),
        .o_a_gt_b (w_a_gt_b),
        .o_a_eq_b (w_a_eq_b),
        .o_b_gt_a (w_b_gt_a)
    );

    assign w_accept = in_valid && r_in_ready;
    // Equal magnitudes never replace the stored element, keeping the earliest.
    assign w_take   = !w_a_eq_b && (r_min ? w_b_gt_a : w_a_gt_b);
    assign w_last   = (r_count == (r_len - c_LEN_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_min       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_empty <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (len == c_LEN_ZERO) begin
                            r_state     <= S_DONE;
                            r_best      <= '0;
                            r_best_idx  <= '0;
                            r_out_empty <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= S_FIRST;
                            r_len       <= len;
                            r_min       <= find_min;
                            r_count     <= '0;
                            r_out_empty <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                S_FIRST: begin
                    if (w_accept) begin
                        r_best     <= in_data;
                        r_best_idx <= '0;
                        r_count    <= c_LEN_ONE;
                        if (r_len == c_LEN_ONE) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_take) begin
                            r_best     <= in_data;
                            r_best_idx <= r_count;
                        end
                        r_count <= r_count + c_LEN_ONE;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // A start coinciding with this handshake is dropped: IDLE only.
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_empty <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_empty <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_best;
    assign out_index = r_best_idx;
    assign out_empty = r_out_empty;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: doc/fp_max_reducer.md
FP_MAX_REDUCER -- requirements
Module: fp_max_reducer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default taken from system_constants.svh (32), meaning the floating-point word width, with the MSB as the sign.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning the width of the burst length and index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a reduction; honoured only in IDLE.
REQ-006 SHALL have port len, input, LEN_WIDTH bits: number of elements in the burst; sampled with start.
REQ-007 SHALL have port find_min, input, 1 bit: 0 selects the largest magnitude, 1 the smallest; sampled with start.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH): the element stream.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-010 SHALL have ports out_data (output, DATA_WIDTH), out_index (output, LEN_WIDTH) and out_empty (output, 1): the result word, its position, and the empty-burst flag.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL instantiate exactly one positive_comparator on in_data[DATA_WIDTH-2:0] versus best[DATA_WIDTH-2:0]; the sign bit is excluded from every comparison.
REQ-013 SHALL implement the states IDLE, FIRST, RUN and DONE.
REQ-014 IDLE: in_ready=0 and out_valid=0.
- start with len=0: go to DONE with out_empty=1, out_data=0, out_index=0.
- start with len>0: latch len and find_min, clear count, go to FIRST.
REQ-015 FIRST: in_ready=1.
- Element accepted (in_valid&&in_ready): best<=in_data, best_idx<=0, count<=1.
- Then go to DONE if len==1, otherwise go to RUN.
REQ-016 RUN: in_ready=1. On each accepted element:
- best/best_idx <= in_data/count if (find_min=0 and a_gt_b) or (find_min=1 and b_gt_a), where a=in_data and b=best.
- count <= count+1.
REQ-017 Ties (a_eq_b) SHALL keep the earlier element and index.
REQ-018 RUN SHALL go to DONE on the cycle the element with count==len-1 is accepted; that element takes part in the comparison.
REQ-019 DONE: out_valid=1, out_empty=0 unless entered per REQ-014, and outputs held stable.
- out_ready=1: go to IDLE next cycle.
- out_ready=0: hold indefinitely.
REQ-020 out_data SHALL be the full stored word including the original sign bit.
REQ-021 Latency: out_valid SHALL rise on the first edge after the last element handshake; for len=0, one edge after start.
REQ-022 Cycles with in_valid=0 in FIRST or RUN SHALL stall without changing state, count or best.
REQ-023 start, len and find_min SHALL be ignored while busy=1.
REQ-024 in_data SHALL be ignored when in_ready=0.
REQ-025 count SHALL be LEN_WIDTH bits, never wraps (len-1 <= 2^LEN_WIDTH-2), and out_index SHALL equal best_idx.
REQ-026 start in the same cycle as a DONE handshake SHALL NOT be accepted; the new start is taken from IDLE only.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force the state to IDLE and clear best, best_idx, count, the latched len and the latched mode.
REQ-028 Outputs SHALL read out_valid=0, in_ready=0, busy=0, out_data=0, out_index=0, out_empty=0 while rst_n=0.
REQ-029 Reset mid-burst SHALL discard the partial result; after release the block waits in IDLE for a new start.

Verification
REQ-030 Max case: len=3, find_min=0, stream 0x40400000 (3.0), 0xC0A00000 (-5.0), 0x3F800000 (1.0) -> out_data=0xC0A00000, out_index=1, out_valid one cycle after the third handshake.
REQ-031 Min case: same stream, find_min=1 -> out_data=0x3F800000, out_index=2.
REQ-032 Tie case: len=3, find_min=0, stream 0x40000000, 0xC0000000, 0x40000000 -> out_data=0x40000000, out_index=0.
REQ-033 Empty and single bursts:
- start with len=0 -> out_valid=1, out_empty=1, out_data=0 the next cycle.
- start with len=1 and 0x3F800000 -> out_index=0, out_empty=0.
REQ-034 Stall and backpressure: in_valid gaps of 3 cycles between elements, then out_ready held low 5 cycles -> result unchanged and stable, start pulses during DONE ignored, IDLE entered one cycle after out_ready=1.
REQ-035 Reset mid-operation: rst_n pulsed low after 2 of 4 elements -> busy=0 and in_ready=0 asynchronously; a new len=2 burst then returns the correct result.
